// File: rtl/dmem_pkg.sv
// Shared definitions for dmem_pipe: RV32 load/store funct3 codes, FSM states
// and the funct3/offset to byte-lane mapping used for sub-word stores.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Byte enables for a store; offsets are expected to be already aligned.
   function automatic logic [3:0] lane_mask(input logic [2:0] funct3,
                                            input logic [1:0] offset);
      case (funct3)
         F3_B:    lane_mask = 4'b0001 << offset;
         F3_H:    lane_mask = offset[1] ? 4'b1100 : 4'b0011;
         F3_W:    lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Final-stage load formatter: selects the byte/halfword addressed by offset
// and sign- or zero-extends it according to funct3.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   output logic [31:0] rdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'(word >> {offset, 3'b000});
      half_sel = offset[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
         F3_W:    rdata = word;
         F3_BU:   rdata = {24'h000000, byte_sel};
         F3_HU:   rdata = {16'h0000, half_sel};
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined RV32 data memory with byte-lane stores, fixed RD_LAT response latency
// and self-clear after reset. Define DMEM_MISALIGN_TRAP_EN to fault misaligned/illegal accesses.
module dmem_pipe
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  init_done
);

   localparam int unsigned IW = $clog2(DEPTH);

   state_t        state;
   logic [IW-1:0] clr_idx;
   logic [31:0]   mem [DEPTH];

   logic          accept;
   logic [IW-1:0] idx;
   logic [1:0]    offset;
   logic          err;
   logic [3:0]    wmask;
   logic [31:0]   wdata_rep;

   logic [RD_LAT-1:0] vld_q;
   logic [31:0]       word_q [RD_LAT];
   logic [2:0]        f3_q   [RD_LAT];
   logic [1:0]        off_q  [RD_LAT];
   logic              we_q   [RD_LAT];
   logic              err_q  [RD_LAT];
   logic [31:0]       aligned;

   logic unused_addr;

   assign req_ready   = (state == ST_RUN);
   assign init_done   = req_ready;
   assign accept      = req_valid && req_ready;
   assign idx         = req_addr[IW+1:2];
   assign unused_addr = ^req_addr[ADDR_WIDTH-1:IW+2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_INIT;
         clr_idx <= '0;
      end else if (state == ST_INIT) begin
         clr_idx <= clr_idx + 1'b1;
         if (clr_idx == IW'(DEPTH - 1)) state <= ST_RUN;
      end
   end

   always_comb begin
      offset = req_addr[1:0];
      err    = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      case (req_funct3)
         F3_H, F3_HU:            err = req_addr[0];
         F3_W:                   err = |req_addr[1:0];
         3'b011, 3'b110, 3'b111: err = 1'b1;
         default:                err = 1'b0;
      endcase
`else
      // Misaligned halfword/word accesses are truncated to their natural boundary.
      case (req_funct3)
         F3_H, F3_HU: offset[0] = 1'b0;
         F3_W:        offset    = 2'b00;
         default:     offset    = req_addr[1:0];
      endcase
`endif
      wmask = (accept && req_we && !err) ? lane_mask(req_funct3, offset) : 4'b0000;
      case (req_funct3)
         F3_B:    wdata_rep = {4{req_wdata[7:0]}};
         F3_H:    wdata_rep = {2{req_wdata[15:0]}};
         default: wdata_rep = req_wdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == ST_INIT) begin
            mem[clr_idx] <= '0;
         end else begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (wmask[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= accept;
         for (int unsigned s = 1; s < RD_LAT; s++) vld_q[s] <= vld_q[s-1];
      end
   end

   // Payload needs no reset: every output use is qualified by vld_q.
   always_ff @(posedge clk) begin
      if (accept) begin
         word_q[0] <= mem[idx];
         f3_q[0]   <= req_funct3;
         off_q[0]  <= offset;
         we_q[0]   <= req_we;
         err_q[0]  <= err;
      end
      for (int unsigned s = 1; s < RD_LAT; s++) begin
         word_q[s] <= word_q[s-1];
         f3_q[s]   <= f3_q[s-1];
         off_q[s]  <= off_q[s-1];
         we_q[s]   <= we_q[s-1];
         err_q[s]  <= err_q[s-1];
      end
   end

   dmem_load_align u_align (
      .word   (word_q[RD_LAT-1]),
      .funct3 (f3_q[RD_LAT-1]),
      .offset (off_q[RD_LAT-1]),
      .rdata  (aligned)
   );

   assign rsp_valid = vld_q[RD_LAT-1];
   assign rsp_rdata = (rsp_valid && !we_q[RD_LAT-1] && !err_q[RD_LAT-1]) ? aligned : '0;
`ifdef DMEM_MISALIGN_TRAP_EN
   assign rsp_err   = rsp_valid && err_q[RD_LAT-1];
`else
   assign rsp_err   = 1'b0;
`endif

endmodule
